// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   RV32I-subset multi-cycle core. Each instruction steps through
//   FETCH/DECODE/EXECUTE/MEM/WB states. Instruction fetch and data access
//   share one memory port with a req/ready handshake, so memory wait states
//   stall the core. An unsupported opcode parks the core in HALT until reset.
//
// Parameters
//   XLEN      datapath and address width (>= 32)
//   RESET_PC  PC value loaded on reset
//   NREGS     architectural registers (16 or 32); x0 reads 0, writes ignored
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   mem_req / mem_we     request valid (held until mem_ready) / 1 = store
//   mem_addr / mem_wdata word-aligned byte address / store data (rs2)
//   mem_rdata            read data, sampled when mem_req & mem_ready
//   mem_ready            transfer completes on the edge where mem_req & mem_ready
//   pc                   current PC register
//   retire               high in the last cycle of each instruction
//   halted               sticky, set on unsupported opcode
module multicycle_datapath #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     NREGS    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halted
);

  localparam int unsigned     RW   = $clog2(NREGS);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_t;

  state_t          state, state_next;
  logic            started;
  logic [XLEN-1:0] ir, oldpc, a_reg, b_reg, alu_out, mdr;
  logic [XLEN-1:0] rf [NREGS];

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [RW-1:0]   rd_idx, rs1_idx, rs2_idx;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] alu_b, alu_result;
  logic [2:0]      funct_ctl, alu_ctl;
  logic            rf_we;
  logic [XLEN-1:0] rf_wdata;

  // Register indices wider than the file wrap by dropping upper bits.
  assign opcode  = ir[6:0];
  assign funct3  = ir[14:12];
  assign rd_idx  = ir[7 +: RW];
  assign rs1_idx = ir[15 +: RW];
  assign rs2_idx = ir[20 +: RW];

  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // The register file is never reset, so x0 is forced to zero on read.
  assign rs1_val = (rs1_idx == '0) ? '0 : rf[rs1_idx];
  assign rs2_val = (rs2_idx == '0) ? '0 : rf[rs2_idx];

  assign mem_wdata = b_reg;

  // funct7 bit 30 selects sub only for register-register ops.
  always_comb begin
    funct_ctl = ALU_ADD;
    case (funct3)
      3'b000:  funct_ctl = (opcode == OP_R && ir[30]) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_ctl = ALU_SLT;
      3'b110:  funct_ctl = ALU_OR;
      3'b111:  funct_ctl = ALU_AND;
      default: funct_ctl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_b   = b_reg;
    alu_ctl = ALU_ADD;
    case (state)
      S_EXECR:  alu_ctl = funct_ctl;
      S_EXECI: begin
        alu_b   = imm_i;
        alu_ctl = funct_ctl;
      end
      S_MEMADR: alu_b = (opcode == OP_STORE) ? imm_s : imm_i;
      default: ;
    endcase
  end

  always_comb begin
    case (alu_ctl)
      ALU_ADD: alu_result = a_reg + alu_b;
      ALU_SUB: alu_result = a_reg - alu_b;
      ALU_AND: alu_result = a_reg & alu_b;
      ALU_OR:  alu_result = a_reg | alu_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, $signed(a_reg) < $signed(alu_b)};
      default: alu_result = a_reg + alu_b;
    endcase
  end

  // The first cycle after reset release is kept idle (started=0) so that
  // mem_req is low throughout reset and comes up one cycle later.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {pc[XLEN-1:2], 2'b00};
    retire     = 1'b0;
    halted     = 1'b0;
    rf_we      = 1'b0;
    rf_wdata   = alu_out;
    case (state)
      S_FETCH: begin
        mem_req = started;
        if (started && mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_I:              state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_HALT;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        mem_req  = 1'b1;
        mem_addr = {alu_out[XLEN-1:2], 2'b00};
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we      = 1'b1;
        rf_wdata   = mdr;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {alu_out[XLEN-1:2], 2'b00};
        if (mem_ready) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: state_next = S_ALUWB;
      S_ALUWB: begin
        rf_we      = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        rf_we      = 1'b1;
        rf_wdata   = oldpc + FOUR;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

  // DECODE precomputes the branch/jump target from the instruction's own PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      started <= 1'b0;
      pc      <= RESET_PC;
      ir      <= '0;
      oldpc   <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
      case (state)
        S_FETCH: begin
          if (mem_req && mem_ready) begin
            ir    <= mem_rdata;
            oldpc <= pc;
            pc    <= pc + FOUR;
          end
        end
        S_DECODE: begin
          a_reg   <= rs1_val;
          b_reg   <= rs2_val;
          alu_out <= oldpc + ((opcode == OP_JAL) ? imm_j : imm_b);
        end
        S_MEMADR, S_EXECR, S_EXECI: alu_out <= alu_result;
        S_MEMRD: begin
          if (mem_ready) mdr <= mem_rdata;
        end
        S_BEQ: begin
          if (a_reg == b_reg) pc <= alu_out;
        end
        S_JAL: pc <= alu_out;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we && rd_idx != '0) rf[rd_idx] <= rf_wdata;
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
module tb_multicycle_datapath;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] dmem    [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] m_rf    [32];
  logic [31:0] m_pc;

  logic [2:0] i_f3tab [4] = '{3'b000, 3'b111, 3'b110, 3'b010};

  multicycle_datapath #(.XLEN(32), .RESET_PC(RESET_PC), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] encI(input int imm, input int rs1, input logic [2:0] f3,
                                       input int rd, input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
  endfunction

  function automatic logic [31:0] encR(input logic [6:0] f7, input int rs2, input int rs1,
                                       input logic [2:0] f3, input int rd);
    return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] encS(input int imm, input int rs2, input int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] encB(input int imm, input int rs2, input int rs1);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] encJ(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction

  task automatic place(input logic [31:0] ins);
    ref_mem[m_pc[11:2]] = ins;
    dmem[m_pc[11:2]]    = ins;
  endtask

  // Executes the instruction at m_pc in the ISA model, serves the DUT's
  // memory requests with fw/dw wait cycles and checks bus, timing and PC.
  task automatic applyStimulus(input int fw, input int dw);
    logic [31:0] ins, a, b, res, next_pc, exp_wdata;
    logic [31:0] immI, immS, immB, immJ;
    logic [31:0] exp_addr [2];
    logic        exp_we   [2];
    int          exp_wait [2];
    int          rd, rs1, rs2, ntx, cpi, cyc, tx, wcnt;
    logic        wr;
    bit          done;
    ins  = ref_mem[m_pc[11:2]];
    rd   = int'(ins[11:7]);
    rs1  = int'(ins[19:15]);
    rs2  = int'(ins[24:20]);
    a    = m_rf[rs1];
    b    = m_rf[rs2];
    immI = 32'($signed(ins[31:20]));
    immS = 32'($signed({ins[31:25], ins[11:7]}));
    immB = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    immJ = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    ntx = 1; cpi = 4; wr = 1'b0; res = '0; exp_wdata = '0;
    exp_addr[0] = m_pc; exp_we[0] = 1'b0; exp_wait[0] = fw;
    exp_addr[1] = '0;   exp_we[1] = 1'b0; exp_wait[1] = dw;
    next_pc = m_pc + 32'd4;
    case (ins[6:0])
      7'h03: begin
        cpi = 5; ntx = 2; wr = 1'b1;
        exp_addr[1] = (a + immI) & ~32'h3;
        res = ref_mem[exp_addr[1][11:2]];
      end
      7'h23: begin
        ntx = 2; exp_we[1] = 1'b1; exp_wdata = b;
        exp_addr[1] = (a + immS) & ~32'h3;
        ref_mem[exp_addr[1][11:2]] = b;
      end
      7'h33, 7'h13: begin
        logic [31:0] op2;
        op2 = (ins[6:0] == 7'h33) ? b : immI;
        wr = 1'b1;
        case (ins[14:12])
          3'b000:  res = (ins[6:0] == 7'h33 && ins[30]) ? a - op2 : a + op2;
          3'b111:  res = a & op2;
          3'b110:  res = a | op2;
          3'b010:  res = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
          default: res = a + op2;
        endcase
      end
      7'h63: begin
        cpi = 3;
        if (a == b) next_pc = m_pc + immB;
      end
      7'h6f: begin
        cpi = 3; wr = 1'b1;
        res = m_pc + 32'd4;
        next_pc = m_pc + immJ;
      end
      default: ;
    endcase

    cyc = 0; tx = 0; wcnt = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      mem_ready = 1'b0;
      if (mem_req === 1'b1) begin
        if (tx < ntx) begin
          checkOutput($sformatf("addr@%h.%0d", m_pc, tx), mem_addr, exp_addr[tx]);
          checkOutput($sformatf("we@%h.%0d", m_pc, tx), {31'b0, mem_we}, {31'b0, exp_we[tx]});
          if (exp_we[tx]) checkOutput($sformatf("wdata@%h", m_pc), mem_wdata, exp_wdata);
          if (wcnt == exp_wait[tx]) begin
            mem_ready = 1'b1;
            mem_rdata = mem_we ? 32'h0 : dmem[mem_addr[11:2]];
            if (mem_we) dmem[mem_addr[11:2]] = mem_wdata;
            tx++;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          checkOutput($sformatf("extra_req@%h", m_pc), {31'b0, mem_req}, 32'h0);
        end
      end
      #1;
      if (retire === 1'b1) done = 1;
      @(posedge clk);
      #1 mem_ready = 1'b0;
    end
    checkOutput($sformatf("retired@%h", m_pc), {31'b0, done}, 32'h1);
    checkOutput($sformatf("cycles@%h", m_pc), cyc, cpi + fw + ((ntx == 2) ? dw : 0));
    checkOutput($sformatf("transfers@%h", m_pc), tx, ntx);
    checkOutput($sformatf("pc_after@%h", m_pc), pc, next_pc);
    if (wr && rd != 0) m_rf[rd] = res;
    m_pc = next_pc;
  endtask

  // Asserts reset from the current point, checks the reset outputs and
  // releases it; the first cycle after release must stay request-free.
  task automatic doReset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    checkOutput("rst_pc", pc, RESET_PC);
    checkOutput("rst_req", {31'b0, mem_req}, 32'h0);
    checkOutput("rst_retire", {31'b0, retire}, 32'h0);
    checkOutput("rst_halted", {31'b0, halted}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("startup_idle_req", {31'b0, mem_req}, 32'h0);
    m_pc = RESET_PC;
  endtask

  initial begin
    int kind, rd, rs1, rs2, imm, sel;
    logic [6:0] f7;
    logic [2:0] f3;
    rst_n = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc = RESET_PC;
    #2;
    doReset();

    // Directed program.
    place(encI(5, 0, 3'b000, 1, 7'h13));  applyStimulus(0, 0);
    place(encI(7, 0, 3'b000, 2, 7'h13));  applyStimulus(0, 0);
    place(encR(7'h00, 2, 1, 3'b000, 3));  applyStimulus(0, 0);
    place(encS(8, 3, 0));                 applyStimulus(0, 3);
    place(encI(8, 0, 3'b010, 4, 7'h03));  applyStimulus(0, 3);
    place(encS(12, 4, 0));                applyStimulus(1, 0);
    place(encJ(32'h20 - 32'h118, 0));     applyStimulus(0, 0);
    place(encB(-8, 1, 1));                applyStimulus(0, 0);
    place(encI(1, 0, 3'b000, 5, 7'h13));  applyStimulus(0, 0);
    place(encI(2, 0, 3'b000, 6, 7'h13));  applyStimulus(2, 0);
    place(encB(-8, 2, 1));                applyStimulus(0, 0);
    place(encJ(32'h1C, 0));               applyStimulus(0, 0);
    place(encJ(16, 1));                   applyStimulus(0, 0);
    place(encI(9, 0, 3'b000, 0, 7'h13));  applyStimulus(0, 0);
    place(encS(16, 0, 0));                applyStimulus(0, 1);
    place(encS(20, 1, 0));                applyStimulus(0, 0);

    // Randomised program against the ISA model.
    for (int k = 1; k < 8; k++) begin
      imm = int'($urandom_range(0, 4095)) - 2048;
      place(encI(imm, 0, 3'b000, k, 7'h13));
      applyStimulus(int'($urandom_range(0, 2)), 0);
    end
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 4));
      rd   = int'($urandom_range(1, 7));
      rs1  = int'($urandom_range(0, 7));
      rs2  = int'($urandom_range(0, 7));
      imm  = int'($urandom_range(0, 4095)) - 2048;
      case (kind)
        0: place(encI(imm, rs1, i_f3tab[$urandom_range(0, 3)], rd, 7'h13));
        1: begin
          sel = int'($urandom_range(0, 4));
          f7 = (sel == 1) ? 7'h20 : 7'h00;
          case (sel)
            0, 1:    f3 = 3'b000;
            2:       f3 = 3'b111;
            3:       f3 = 3'b110;
            default: f3 = 3'b010;
          endcase
          place(encR(f7, rs2, rs1, f3, rd));
        end
        2: place(encI(32'h600 + 4 * rs2, 0, 3'b010, rd, 7'h03));
        3: place(encB(4 * int'($urandom_range(1, 3)), rs2, rs1));
        default: place(encS(32'h600 + 4 * rs2, rs1, 0));
      endcase
      applyStimulus(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      if (kind <= 2) begin
        place(encS(32'h600 + 4 * rd, rd, 0));
        applyStimulus(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end
    end

    // Unsupported opcode halts the core with no further requests.
    place(32'h0000_007F);
    @(negedge clk);
    checkOutput("halt_fetch_addr", mem_addr, m_pc);
    mem_ready = 1'b1;
    mem_rdata = dmem[mem_addr[11:2]];
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("halt_decode_halted", {31'b0, halted}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("halt_halted", {31'b0, halted}, 32'h1);
      checkOutput("halt_req", {31'b0, mem_req}, 32'h0);
      checkOutput("halt_retire", {31'b0, retire}, 32'h0);
    end
    checkOutput("halt_pc", pc, m_pc + 32'd4);

    // Reset out of HALT, then reset again in the middle of a load.
    doReset();
    place(encI(8, 0, 3'b010, 6, 7'h03));
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("midrd_fetch_addr", mem_addr, RESET_PC);
    mem_ready = 1'b1;
    mem_rdata = dmem[mem_addr[11:2]];
    @(posedge clk);
    #1 mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrd_req", {31'b0, mem_req}, 32'h1);
    checkOutput("midrd_addr", mem_addr, 32'h8);
    doReset();
    place(encI(-3, 0, 3'b000, 7, 7'h13));  applyStimulus(0, 0);
    place(encS(32'h30, 7, 0));              applyStimulus(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
